muldiv_sequencer: RTL
=====================

# muldiv_sequencer

Iterative multiply/divide sequencer in the Execute stage. Accepts one multi-cycle ALU operation at a time, runs a shift-add multiplier or restoring divider for WIDTH cycles, and drives `alu_ready`, which feeds the hazard unit's `x_alu_ready` to stall Fetch, Decode and Execute. Holds the result until the pipeline accepts it, and aborts on a control-hazard flush.

## Interface
- WIDTH, 32, operand and result width in bits; must be ≥ 2.
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  Execute presents a multi-cycle op this cycle; sampled only in IDLE
- op  in  2  operation: 00 MUL (low product), 01 MULHU (high product, unsigned), 10 DIVU (quotient), 11 REMU (remainder)
- src_a  in  WIDTH  multiplicand or dividend; captured on start
- src_b  in  WIDTH  multiplier or divisor; captured on start
- accept  in  1  pipeline advances past Execute this cycle (no `x_stall` from other causes)
- flush  in  1  abort the current op (jump/branch taken)
- alu_ready  out  1  low while an op is pending or running
- busy  out  1  state is not IDLE
- result  out  WIDTH  op result; valid in DONE
- illegal  out  1  op is not supported in this build; valid in DONE

## Operation
- States: IDLE, RUN, DONE. On reset: IDLE, counter 0, accumulator/quotient/remainder 0, `result`=0, `illegal`=0, `busy`=0, `alu_ready`=1.
- IDLE: if `start` & ~`flush`, capture `src_a`, `src_b` and `op`; load counter with WIDTH-1; go to RUN. Otherwise stay.
- RUN: one iteration per cycle. When counter==0, latch `result` and go to DONE; otherwise decrement the counter.
  - MUL/MULHU: 2·WIDTH-bit unsigned shift-add. `result` is the low or high WIDTH bits.
  - DIVU/REMU: unsigned restoring division, one quotient bit per cycle. Divisor 0 gives quotient all ones and remainder = `src_a`.
- DONE: `result` is held stable. If `accept`, go to IDLE. A `start` in the same cycle is ignored; a new op needs a fresh `start` in IDLE.
- `alu_ready` is combinational:
  - 1 in DONE.
  - 1 in IDLE when `start`=0.
  - 0 in IDLE when `start`=1, and 0 throughout RUN.
- `flush` in any state: go to IDLE on the next edge. `flush` has priority over `start` and `accept`. `result` is not updated.
- Reset asserted mid-operation: immediate return to IDLE, with every output at its reset value.
- All arithmetic is unsigned. Intermediate products are 2·WIDTH bits, and the partial remainder is WIDTH+1 bits. No overflow is possible.

## Timing
- Latency: `start` in cycle 0, RUN in cycles 1..WIDTH, DONE from cycle WIDTH+1. `alu_ready` is low for exactly WIDTH+1 cycles when `accept` is high at DONE.
- `result` is registered and changes only on entry to DONE.
- Throughput: one op per WIDTH+2 cycles minimum, because DONE→IDLE costs one cycle.
- `start` arriving during RUN or DONE is ignored. The Execute stage holds the op via `alu_ready`=0.

## Configuration
- `MULDIV_DIV_EN` defined: all four ops are supported as above.
- `MULDIV_DIV_EN` undefined:
  - The divider logic is not compiled.
  - DIVU/REMU skip RUN and go IDLE→DONE in one cycle with `result`=0 and `illegal`=1.
  - MUL/MULHU behave identically to the enabled build, and `illegal` stays 0 for them.

## Structure
- Package `muldiv_pkg` holds:
  - the op encoding (`OP_MUL`, `OP_MULHU`, `OP_DIVU`, `OP_REMU`);
  - the state encoding (`ST_IDLE`, `ST_RUN`, `ST_DONE`);
  - the default WIDTH constant.
- One combinational sub-module, `muldiv_step`, computes a single shift-add or restoring-subtract iteration. The FSM, counter and operand registers live in `muldiv_sequencer`.

## Test plan
- MUL 7×6, `accept`=1 → `alu_ready` low for 33 cycles; `result`=42 in DONE; IDLE the cycle after.
- MULHU 0xFFFFFFFF×0xFFFFFFFF → `result`=0xFFFFFFFE; MUL on the same operands → 0x00000001.
- DIVU 100/7 → 14; REMU 100/7 → 2; DIVU 5/0 → 0xFFFFFFFF; REMU 5/0 → 5.
- `flush` at RUN cycle 10 → IDLE next edge, `alu_ready`=1, `busy`=0, `result` unchanged from prior op.
- DONE with `accept`=0 for 4 cycles, `start` toggling → state stays DONE, `result` stable, new op starts only after return to IDLE.
- Build without `MULDIV_DIV_EN`: DIVU 100/7 → DONE one cycle after start, `result`=0, `illegal`=1. Reset pulse mid-MUL → all outputs at reset values immediately.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared encodings and defaults for the iterative multiply/divide sequencer.
package muldiv_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    OP_MUL   = 2'b00,
    OP_MULHU = 2'b01,
    OP_DIVU  = 2'b10,
    OP_REMU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // Bit 1 of the op selects the divider; bit 0 selects the high/remainder half.
  function automatic logic op_is_div(input logic [1:0] o);
    return o[1];
  endfunction

  function automatic logic op_takes_hi(input logic [1:0] o);
    return o[0];
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add multiply or restoring-divide step.
// Divider path is compiled only when MULDIV_DIV_EN is defined.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] hi,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] opnd,
  output logic [WIDTH-1:0] hi_n,
  output logic [WIDTH-1:0] lo_n
);

  logic [WIDTH:0] sum;

  // Multiply: lo holds the remaining multiplier bits, product shifts in from the top.
  always_comb begin
    sum = {1'b0, hi};
    if (lo[0]) sum = {1'b0, hi} + {1'b0, opnd};
  end

`ifdef MULDIV_DIV_EN
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // Divide: hi is the partial remainder, lo shifts dividend out and quotient in.
  always_comb begin
    shifted = {hi, lo[WIDTH-1]};
    diff    = shifted - {1'b0, opnd};
    if (is_div) begin
      hi_n = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
      lo_n = {lo[WIDTH-2:0], ~diff[WIDTH]};
    end else begin
      hi_n = sum[WIDTH:1];
      lo_n = {sum[0], lo[WIDTH-1:1]};
    end
  end
`else
  logic unused_is_div;
  assign unused_is_div = is_div;
  assign hi_n = sum[WIDTH:1];
  assign lo_n = {sum[0], lo[WIDTH-1:1]};
`endif

endmodule

// File: rtl/muldiv_sequencer.sv
// Execute-stage multi-cycle MUL/MULHU/DIVU/REMU sequencer with flush abort.
// MULDIV_DIV_EN enables the divider; without it DIVU/REMU complete as illegal.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             accept,
  input  logic             flush,
  output logic             alu_ready,
  output logic             busy,
  output logic [WIDTH-1:0] result,
  output logic             illegal
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             illegal_q, illegal_d;
  logic [WIDTH-1:0] hi_n, lo_n;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div (op_is_div(op_q)),
    .hi     (hi_q),
    .lo     (lo_q),
    .opnd   (opnd_q),
    .hi_n   (hi_n),
    .lo_n   (lo_n)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    opnd_d    = opnd_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    result_d  = result_q;
    illegal_d = illegal_q;
    if (flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (start) begin
`ifndef MULDIV_DIV_EN
          if (op_is_div(op)) begin
            state_d   = ST_DONE;
            result_d  = '0;
            illegal_d = 1'b1;
          end else
`endif
          begin
            state_d   = ST_RUN;
            op_d      = op;
            cnt_d     = CW'(WIDTH - 1);
            hi_d      = '0;
            // Divider keeps the divisor as operand and shifts the dividend through lo.
            opnd_d    = op_is_div(op) ? src_b : src_a;
            lo_d      = op_is_div(op) ? src_a : src_b;
            illegal_d = 1'b0;
          end
        end
        ST_RUN: begin
          hi_d = hi_n;
          lo_d = lo_n;
          if (cnt_q == '0) begin
            state_d  = ST_DONE;
            result_d = op_takes_hi(op_q) ? hi_n : lo_n;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        ST_DONE: if (accept) state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      op_q      <= OP_MUL;
      opnd_q    <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      result_q  <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      opnd_q    <= opnd_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      result_q  <= result_d;
      illegal_q <= illegal_d;
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign alu_ready = (state_q == ST_DONE) || ((state_q == ST_IDLE) && !start);
  assign result    = result_q;
  assign illegal   = illegal_q;

endmodule
